// File: rtl/cnn_pkg.sv
// Shared CNN datapath widths and the saturating clamp used by tap multipliers and the adder tree.
package cnn_pkg;
    localparam int DATA_W      = 8;
    localparam int PROD_W      = 16;
    localparam int KERNEL_TAPS = 9;

    localparam int SAT_MAX = (2 ** (DATA_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_W - 1));

    function automatic logic signed [DATA_W-1:0] sat_clamp(input logic signed [31:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = DATA_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            r = DATA_W'(SAT_MIN);
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// One image row of delay: o_dat is the sample shifted in DEPTH enables ago.
// Shifts only when i_en is high; contents are not reset since the row/col gating upstream hides stale data.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_dat,
    output logic signed [DATA_W-1:0] o_dat
);
    logic signed [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dat = r_mem[DEPTH-1];
endmodule

// File: rtl/conv_window_mult.sv
// 3x3 sliding-window tap multiplier with clamped fixed-point scaling; CONV_ROUND_EN selects round-half-up over floor.
// Latency: tree/results two edges after the completing pixel's edge; no backpressure, one window per cycle.
module conv_window_mult
    import cnn_pkg::*;
#(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int FRAC_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_in,
    input  logic                     w_load,
    input  logic        [3:0]        w_idx,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     tree,
    output logic signed [DATA_W-1:0] result_0,
    output logic signed [DATA_W-1:0] result_1,
    output logic signed [DATA_W-1:0] result_2,
    output logic signed [DATA_W-1:0] result_3,
    output logic signed [DATA_W-1:0] result_4,
    output logic signed [DATA_W-1:0] result_5,
    output logic signed [DATA_W-1:0] result_6,
    output logic signed [DATA_W-1:0] result_7,
    output logic signed [DATA_W-1:0] result_8
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
`ifdef CONV_ROUND_EN
    localparam int RND = (FRAC_BITS > 0) ? ((1 << FRAC_BITS) / 2) : 0;
`endif

    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic signed [DATA_W-1:0] r_wt   [KERNEL_TAPS];
    logic signed [DATA_W-1:0] r_win  [KERNEL_TAPS];
    logic signed [PROD_W-1:0] r_prod [KERNEL_TAPS];
    logic signed [DATA_W-1:0] r_res  [KERNEL_TAPS];
    logic                     r_win_vld;
    logic                     r_prod_vld;
    logic                     r_tree;

    logic                     w_complete;
    logic signed [DATA_W-1:0] w_lb0;
    logic signed [DATA_W-1:0] w_lb1;
    logic signed [DATA_W-1:0] w_new    [3];
    logic signed [31:0]       w_scaled [KERNEL_TAPS];

    line_buffer #(.DEPTH(IMG_W)) u_lb0 (.clk(clk), .i_en(pix_valid), .i_dat(pix_in), .o_dat(w_lb0));
    line_buffer #(.DEPTH(IMG_W)) u_lb1 (.clk(clk), .i_en(pix_valid), .i_dat(w_lb0),  .o_dat(w_lb1));

    // Window rows ordered oldest first: two rows back, one row back, current row.
    assign w_new[0]   = w_lb1;
    assign w_new[1]   = w_lb0;
    assign w_new[2]   = pix_in;
    assign w_complete = pix_valid && (r_row >= RW'(2)) && (r_col >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (r_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_wt[k] <= '0;
            end
        end else if (w_load && (w_idx < 4'(KERNEL_TAPS))) begin
            r_wt[w_idx] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
                r_win[3*i]   <= r_win[3*i+1];
                r_win[3*i+1] <= r_win[3*i+2];
                r_win[3*i+2] <= w_new[i];
            end
        end
    end

    // Weights are read one edge after the window lands, so a same-edge weight write is seen.
    always_ff @(posedge clk) begin
        if (r_win_vld) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_prod[k] <= PROD_W'(r_win[k]) * PROD_W'(r_wt[k]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
`ifdef CONV_ROUND_EN
            w_scaled[k] = (32'(r_prod[k]) + 32'(RND)) >>> FRAC_BITS;
`else
            w_scaled[k] = 32'(r_prod[k]) >>> FRAC_BITS;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_vld  <= 1'b0;
            r_prod_vld <= 1'b0;
            r_tree     <= 1'b0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_res[k] <= '0;
            end
        end else begin
            r_win_vld  <= w_complete;
            r_prod_vld <= r_win_vld;
            r_tree     <= r_prod_vld;
            if (r_prod_vld) begin
                for (int k = 0; k < KERNEL_TAPS; k++) begin
                    r_res[k] <= sat_clamp(w_scaled[k]);
                end
            end
        end
    end

    assign tree     = r_tree;
    assign result_0 = r_res[0];
    assign result_1 = r_res[1];
    assign result_2 = r_res[2];
    assign result_3 = r_res[3];
    assign result_4 = r_res[4];
    assign result_5 = r_res[5];
    assign result_6 = r_res[6];
    assign result_7 = r_res[7];
    assign result_8 = r_res[8];
endmodule

// File: tb/tb_conv_window_mult.sv
// Scoreboard bench: three 4x4 instances (FRAC_BITS 0, 2, 4) share one stimulus stream.
module tb_conv_window_mult;
    logic clk = 1'b0;
    logic rst;
    logic pix_valid;
    logic signed [7:0] pix_in;
    logic w_load;
    logic [3:0] w_idx;
    logic signed [7:0] w_data;
    logic tree_f [3];
    logic signed [7:0] res [3][9];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        conv_window_mult #(.IMG_W(4), .IMG_H(4), .FRAC_BITS(2 * d)) u_dut (
            .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
            .w_load(w_load), .w_idx(w_idx), .w_data(w_data), .tree(tree_f[d]),
            .result_0(res[d][0]), .result_1(res[d][1]), .result_2(res[d][2]),
            .result_3(res[d][3]), .result_4(res[d][4]), .result_5(res[d][5]),
            .result_6(res[d][6]), .result_7(res[d][7]), .result_8(res[d][8])
        );
    end

    typedef struct packed {
        int cyc;
        logic [2:0][8:0][7:0] r;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int wm [9];
    int img [4][4];
    int mr = 0;
    int mc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_tap(input int p, input int w, input int f);
        int v;
        v = p * w;
`ifdef CONV_ROUND_EN
        if (f > 0) v = v + (1 << (f - 1));
`endif
        v = v >>> f;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic step(input logic v, input int p, input logic wl, input int wi, input int wd);
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        pix_in    = p[7:0];
        w_load    = wl;
        w_idx     = wi[3:0];
        w_data    = wd[7:0];
        if (wl && wi <= 8) wm[wi] = wd;
        if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                e.cyc = cyc + 3;
                for (int d = 0; d < 3; d++)
                    for (int k = 0; k < 9; k++)
                        e.r[d][k] = model_tap(img[mr-2+k/3][mc-2+k%3], wm[k], 2 * d);
                q.push_back(e);
            end
            if (mc == 3) begin
                mc = 0;
                mr = (mr == 3) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        w_load = 1'b0;
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        for (int k = 0; k < 9; k++) wm[k] = 0;
        mr = 0;
        mc = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_all(input int w);
        for (int k = 0; k < 9; k++) step(1'b0, 0, 1'b1, k, w);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (tree_f[0] || tree_f[1] || tree_f[2]) begin
            if (q.size() == 0) begin
                check("unexpected_tree", 1, 0);
            end else begin
                e = q.pop_front();
                check("tree_cycle", cyc, e.cyc);
                for (int d = 0; d < 3; d++) begin
                    check($sformatf("tree_f%0d", 2 * d), int'(tree_f[d]), 1);
                    for (int k = 0; k < 9; k++)
                        check($sformatf("res_f%0d_k%0d", 2 * d, k),
                              int'($signed(res[d][k])), int'($signed(e.r[d][k])));
                end
            end
        end
        if (q.size() > 0 && q[0].cyc < cyc) begin
            check("missed_tree", 0, 1);
            void'(q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_in = '0;
        w_load = 1'b0; w_idx = '0; w_data = '0;
        do_reset();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_tree_f%0d", 2 * d), int'(tree_f[d]), 0);
            for (int k = 0; k < 9; k++)
                check($sformatf("rst_res_f%0d_k%0d", 2 * d, k), int'($signed(res[d][k])), 0);
        end

        // Unit weights, ramp frame, then the same frame with pix_valid toggling.
        load_all(1);
        for (int p = 0; p < 16; p++) step(1'b1, p, 1'b0, 0, 0);
        for (int p = 0; p < 16; p++) begin
            step(1'b1, p, 1'b0, 0, 0);
            step(1'b0, 0, 1'b0, 0, 0);
        end

        // Mid-frame reset after 5 pixels, then a fresh frame.
        for (int p = 0; p < 5; p++) step(1'b1, 50 + p, 1'b0, 0, 0);
        do_reset();
        load_all(1);
        for (int p = 0; p < 16; p++) step(1'b1, p, 1'b0, 0, 0);

        // Reset right after a completing pixel cancels its pulse.
        for (int p = 0; p < 11; p++) step(1'b1, p, 1'b0, 0, 0);
        do_reset();
        load_all(1);

        // Weight write coinciding with pixel 10, then an out-of-range write.
        for (int p = 0; p < 16; p++) step(1'b1, p, (p == 10), 4, 3);
        step(1'b0, 0, 1'b1, 9, 77);
        for (int p = 0; p < 16; p++) step(1'b1, p + 20, 1'b0, 0, 0);

        // Saturation at both rails.
        load_all(127);
        for (int p = 0; p < 16; p++) step(1'b1, (p < 8) ? 127 : -128, 1'b0, 0, 0);

        // Rounding / floor on small products of both signs.
        load_all(2);
        for (int p = 0; p < 16; p++) step(1'b1, (p % 2 == 0) ? 3 : -3, 1'b0, 0, 0);

        repeat (8) step(1'b0, 0, 1'b0, 0, 0);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
